// File: rtl/simon_game_controller.sv
`default_nettype none
// ============================================================================
// Module   : simon_game_controller
// Purpose  : Sequencer for the memory-game datapath. Plays the target note
//            sequence (entries 0..level) on the piezo/LED bus, then collects
//            debounced button presses and compares them to the sequence.
//            Emits one-cycle success/fail pulses to the jingle player, then
//            advances the level or consumes a life.
// Ports    : clk, reset (sync, active-high), start (one-cycle new-game
//            request), btn[3:0] (debounced levels, btn[k] = tone k+1)
//            piezo_out/led_out[3:0] (tone code, 0 = silent), success/fail
//            (one-cycle pulses), level[2:0] (current last index),
//            lives_left[1:0], win, game_over.
// Revision : 1.0 - initial release
// ============================================================================
module simon_game_controller #(
    parameter int          TICK_DIV      = 5000000,
    parameter int          ON_TICKS      = 2,
    parameter int          OFF_TICKS     = 1,
    parameter int          TIMEOUT_TICKS = 20,
    parameter int          JINGLE_TICKS  = 12,
    parameter int          MIN_LEVEL     = 2,
    parameter int          MAX_LEVEL     = 7,
    parameter int          LIVES         = 3,
    parameter logic [15:0] SEQ           = 16'hE4E4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [3:0] piezo_out,
    output logic [3:0] led_out,
    output logic       success,
    output logic       fail,
    output logic [2:0] level,
    output logic [1:0] lives_left,
    output logic       win,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHOW_ON  = 3'd1,
        S_SHOW_OFF = 3'd2,
        S_WAIT_IN  = 3'd3,
        S_CELEB    = 3'd4,
        S_PENALTY  = 3'd5,
        S_WIN      = 3'd6,
        S_OVER     = 3'd7
    } state_t;

    // Tick counter only has to reach the longest state duration minus one.
    localparam int c_TMAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int c_TMAX_B = (TIMEOUT_TICKS > JINGLE_TICKS) ? TIMEOUT_TICKS : JINGLE_TICKS;
    localparam int c_TMAX   = (c_TMAX_A > c_TMAX_B) ? c_TMAX_A : c_TMAX_B;
    localparam int c_PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_TW     = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_PW-1:0] c_PRE_LAST     = c_PW'(TICK_DIV - 1);
    localparam logic [c_TW-1:0] c_ON_LAST      = c_TW'(ON_TICKS - 1);
    localparam logic [c_TW-1:0] c_OFF_LAST     = c_TW'(OFF_TICKS - 1);
    localparam logic [c_TW-1:0] c_TIMEOUT_LAST = c_TW'(TIMEOUT_TICKS - 1);
    localparam logic [c_TW-1:0] c_JINGLE_LAST  = c_TW'(JINGLE_TICKS - 1);
    localparam logic [2:0]      c_MIN_LEVEL    = 3'(MIN_LEVEL);
    localparam logic [2:0]      c_MAX_LEVEL    = 3'(MAX_LEVEL);
    localparam logic [1:0]      c_LIVES        = 2'(LIVES);

    state_t          r_state;
    logic [2:0]      r_idx;
    logic [2:0]      r_level;
    logic [1:0]      r_lives;
    logic [3:0]      r_btn_q;
    logic [c_PW-1:0] r_pre;
    logic [c_TW-1:0] r_tcnt;
    logic [3:0]      r_piezo;
    logic            r_success;
    logic            r_fail;
    logic            r_win;
    logic            r_over;

    state_t     w_state_d;
    logic [2:0] w_idx_d;
    logic [2:0] w_level_d;
    logic [1:0] w_lives_d;
    logic       w_success_d;
    logic       w_fail_d;
    logic       w_timer_clr;
    logic [3:0] w_piezo_d;
    logic       w_tick;
    logic [3:0] w_new;
    logic [1:0] w_entry_cur;
    logic [1:0] w_entry_nxt;
    logic [3:0] w_expect;

    assign w_tick      = (r_pre == c_PRE_LAST);
    assign w_new       = btn & ~r_btn_q;
    assign w_entry_cur = SEQ[{r_idx, 1'b0} +: 2];
    assign w_entry_nxt = SEQ[{w_idx_d, 1'b0} +: 2];
    assign w_expect    = 4'b0001 << w_entry_cur;

    // Next-state and datapath updates.
    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_level_d   = r_level;
        w_lives_d   = r_lives;
        w_success_d = 1'b0;
        w_fail_d    = 1'b0;
        w_timer_clr = 1'b0;
        case (r_state)
            S_IDLE, S_WIN, S_OVER: begin
                if (start) begin
                    w_state_d = S_SHOW_ON;
                    w_level_d = c_MIN_LEVEL;
                    w_lives_d = c_LIVES;
                    w_idx_d   = 3'd0;
                end
            end
            S_SHOW_ON: begin
                if (w_tick && (r_tcnt == c_ON_LAST)) begin
                    w_state_d = S_SHOW_OFF;
                end
            end
            S_SHOW_OFF: begin
                if (w_tick && (r_tcnt == c_OFF_LAST)) begin
                    if (r_idx == r_level) begin
                        w_state_d = S_WAIT_IN;
                        w_idx_d   = 3'd0;
                    end else begin
                        w_state_d = S_SHOW_ON;
                        w_idx_d   = r_idx + 3'd1;
                    end
                end
            end
            S_WAIT_IN: begin
                // Simultaneous rising edges never equal the one-hot expectation,
                // so they fall into the wrong-press branch.
                if (w_new != 4'd0) begin
                    if (w_new == w_expect) begin
                        if (r_idx == r_level) begin
                            w_success_d = 1'b1;
                            w_state_d   = S_CELEB;
                        end else begin
                            w_idx_d     = r_idx + 3'd1;
                            w_timer_clr = 1'b1;
                        end
                    end else begin
                        w_fail_d  = 1'b1;
                        w_lives_d = r_lives - 2'd1;
                        w_state_d = S_PENALTY;
                    end
                end else if (w_tick && (r_tcnt == c_TIMEOUT_LAST)) begin
                    w_fail_d  = 1'b1;
                    w_lives_d = r_lives - 2'd1;
                    w_state_d = S_PENALTY;
                end
            end
            S_CELEB: begin
                if (w_tick && (r_tcnt == c_JINGLE_LAST)) begin
                    if (r_level == c_MAX_LEVEL) begin
                        w_state_d = S_WIN;
                    end else begin
                        w_level_d = r_level + 3'd1;
                        w_idx_d   = 3'd0;
                        w_state_d = S_SHOW_ON;
                    end
                end
            end
            S_PENALTY: begin
                if (w_tick && (r_tcnt == c_JINGLE_LAST)) begin
                    if (r_lives == 2'd0) begin
                        w_state_d = S_OVER;
                    end else begin
                        w_idx_d   = 3'd0;
                        w_state_d = S_SHOW_ON;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // Tone bus is computed from the upcoming state so it lines up with the
    // state register once both are clocked.
    always_comb begin
        w_piezo_d = 4'd0;
        if (w_state_d == S_SHOW_ON) begin
            w_piezo_d = {2'b00, w_entry_nxt} + 4'd1;
        end else if (w_state_d == S_WAIT_IN) begin
            if (btn[0])      w_piezo_d = 4'd1;
            else if (btn[1]) w_piezo_d = 4'd2;
            else if (btn[2]) w_piezo_d = 4'd3;
            else if (btn[3]) w_piezo_d = 4'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= 3'd0;
            r_level   <= c_MIN_LEVEL;
            r_lives   <= c_LIVES;
            r_btn_q   <= 4'd0;
            r_pre     <= '0;
            r_tcnt    <= '0;
            r_piezo   <= 4'd0;
            r_success <= 1'b0;
            r_fail    <= 1'b0;
            r_win     <= 1'b0;
            r_over    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_idx     <= w_idx_d;
            r_level   <= w_level_d;
            r_lives   <= w_lives_d;
            r_btn_q   <= btn;
            r_piezo   <= w_piezo_d;
            r_success <= w_success_d;
            r_fail    <= w_fail_d;
            r_win     <= (w_state_d == S_WIN);
            r_over    <= (w_state_d == S_OVER);
            // Every state (and every accepted input) starts a fresh timing window.
            if ((w_state_d != r_state) || w_timer_clr) begin
                r_pre  <= '0;
                r_tcnt <= '0;
            end else if (w_tick) begin
                r_pre  <= '0;
                r_tcnt <= r_tcnt + 1'b1;
            end else begin
                r_pre  <= r_pre + 1'b1;
            end
        end
    end

    assign piezo_out  = r_piezo;
    assign led_out    = r_piezo;
    assign success    = r_success;
    assign fail       = r_fail;
    assign level      = r_level;
    assign lives_left = r_lives;
    assign win        = r_win;
    assign game_over  = r_over;

endmodule
`default_nettype wire

// File: tb/tb_simon_game_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_simon_game_controller
// Purpose  : Directed self-checking bench for simon_game_controller with a
//            small timing configuration (4 clocks per tick).
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_game_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] btn;
    logic [3:0] piezo_out;
    logic [3:0] led_out;
    logic       success;
    logic       fail;
    logic [2:0] level;
    logic [1:0] lives_left;
    logic       win;
    logic       game_over;

    int n_checks = 0;
    int n_fail   = 0;

    // Tone shown for entry i of 16'hE4E4: entries 0,1,2,3,0,1,2,3 -> tone+1.
    int tone_tbl [8] = '{1, 2, 3, 4, 1, 2, 3, 4};

    always #5 clk = ~clk;

    simon_game_controller #(
        .TICK_DIV     (4),
        .ON_TICKS     (2),
        .OFF_TICKS    (1),
        .TIMEOUT_TICKS(8),
        .JINGLE_TICKS (3),
        .MIN_LEVEL    (2),
        .MAX_LEVEL    (3),
        .LIVES        (2),
        .SEQ          (16'hE4E4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .btn       (btn),
        .piezo_out (piezo_out),
        .led_out   (led_out),
        .success   (success),
        .fail      (fail),
        .level     (level),
        .lives_left(lives_left),
        .win       (win),
        .game_over (game_over)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks the whole shown sequence (8 cycles on, 4 off per note), optionally
    // issuing the starting pulse and an extra start at cycle start_at, then
    // steps into WAIT_IN.
    task automatic show(input int lvl, input int exp_lives, input bit kick, input int start_at);
        int cnt = 0;
        for (int n = 0; n <= lvl; n++) begin
            for (int i = 0; i < 12; i++) begin
                logic [3:0] exp_tone;
                exp_tone = (i < 8) ? 4'(tone_tbl[n]) : 4'd0;
                start = (kick && cnt == 0) || (cnt == start_at);
                step();
                start = 1'b0;
                n_checks++;
                if (piezo_out !== exp_tone) begin
                    n_fail++;
                    $display("FAIL show_piezo lvl=%0d note=%0d cyc=%0d got=%0d exp=%0d", lvl, n, i, piezo_out, exp_tone);
                end
                n_checks++;
                if (led_out !== exp_tone) begin
                    n_fail++;
                    $display("FAIL show_led lvl=%0d note=%0d cyc=%0d got=%0d exp=%0d", lvl, n, i, led_out, exp_tone);
                end
                cnt++;
            end
        end
        step();
        n_checks++;
        if (piezo_out !== 4'd0) begin
            n_fail++;
            $display("FAIL wait_in_silent got=%0d exp=0", piezo_out);
        end
        n_checks++;
        if (level !== 3'(lvl)) begin
            n_fail++;
            $display("FAIL show_level got=%0d exp=%0d", level, lvl);
        end
        n_checks++;
        if (lives_left !== 2'(exp_lives)) begin
            n_fail++;
            $display("FAIL show_lives got=%0d exp=%0d", lives_left, exp_lives);
        end
        n_checks++;
        if ({win, game_over} !== 2'b00) begin
            n_fail++;
            $display("FAIL show_flags win/over got=%b exp=00", {win, game_over});
        end
    endtask

    task automatic wait_silent(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            n_checks++;
            if ({piezo_out, success, fail} !== 6'd0) begin
                n_fail++;
                $display("FAIL jingle_silent cyc=%0d piezo=%0d succ=%b fail=%b exp=0/0/0", i, piezo_out, success, fail);
            end
        end
    endtask

    // Enters the correct presses for level L, ending on the success cycle.
    task automatic clear_level(input int lvl);
        for (int k = 0; k <= lvl; k++) begin
            btn = 4'b0001 << (tone_tbl[k] - 1);
            step();
            if (k == lvl) begin
                n_checks++;
                if ({success, fail} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL clear_success lvl=%0d got succ/fail=%b exp=10", lvl, {success, fail});
                end
                btn = 4'd0;
            end else begin
                n_checks++;
                if ({success, fail, piezo_out} !== {2'b00, 4'(tone_tbl[k])}) begin
                    n_fail++;
                    $display("FAIL clear_press lvl=%0d k=%0d got succ=%b fail=%b led=%0d exp=0 0 %0d", lvl, k, success, fail, piezo_out, tone_tbl[k]);
                end
                btn = 4'd0;
                step();
                n_checks++;
                if ({success, fail} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL clear_release lvl=%0d k=%0d got succ/fail=%b exp=00", lvl, k, {success, fail});
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        btn   = 4'd0;
        step();
        step();
        n_checks++;
        if ({piezo_out, led_out, success, fail, win, game_over} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got piezo=%0d led=%0d s=%b f=%b w=%b o=%b exp=all 0", piezo_out, led_out, success, fail, win, game_over);
        end
        n_checks++;
        if (level !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_level got=%0d exp=2", level);
        end
        n_checks++;
        if (lives_left !== 2'd2) begin
            n_fail++;
            $display("FAIL reset_lives got=%0d exp=2", lives_left);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (piezo_out !== 4'd0) begin
                n_fail++;
                $display("FAIL idle_silent cyc=%0d got=%0d exp=0", i, piezo_out);
            end
        end
    endtask

    // Held btn[0] must count once; btn[1] and btn[2] rising while lower
    // buttons stay held are single new presses.
    task automatic test_correct_round();
        btn = 4'b0001;
        step();
        n_checks++;
        if ({success, fail, piezo_out} !== {2'b00, 4'd1}) begin
            n_fail++;
            $display("FAIL round_p0 got s=%b f=%b led=%0d exp=0 0 1", success, fail, piezo_out);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({success, fail, piezo_out} !== {2'b00, 4'd1}) begin
                n_fail++;
                $display("FAIL round_hold cyc=%0d got s=%b f=%b led=%0d exp=0 0 1", i, success, fail, piezo_out);
            end
        end
        btn = 4'b0011;
        step();
        n_checks++;
        if ({success, fail, piezo_out} !== {2'b00, 4'd1}) begin
            n_fail++;
            $display("FAIL round_p1 got s=%b f=%b led=%0d exp=0 0 1", success, fail, piezo_out);
        end
        btn = 4'b0111;
        step();
        n_checks++;
        if ({success, fail, piezo_out} !== {2'b10, 4'd0}) begin
            n_fail++;
            $display("FAIL round_success got s=%b f=%b piezo=%0d exp=1 0 0", success, fail, piezo_out);
        end
        btn = 4'd0;
        wait_silent(11);
        show(3, 2, 1'b0, -1);
    endtask

    task automatic test_wrong_press();
        btn = 4'b1000;
        step();
        n_checks++;
        if ({success, fail} !== 2'b01) begin
            n_fail++;
            $display("FAIL wrong_fail got succ/fail=%b exp=01", {success, fail});
        end
        n_checks++;
        if (lives_left !== 2'd1) begin
            n_fail++;
            $display("FAIL wrong_lives got=%0d exp=1", lives_left);
        end
        btn = 4'd0;
        wait_silent(11);
        show(3, 1, 1'b0, -1);
    endtask

    task automatic test_timeout(input int exp_lives);
        for (int i = 0; i < 31; i++) begin
            step();
            n_checks++;
            if (fail !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early cyc=%0d got fail=%b exp=0", i, fail);
            end
        end
        step();
        n_checks++;
        if ({success, fail} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_fail got succ/fail=%b exp=01", {success, fail});
        end
        n_checks++;
        if (lives_left !== 2'(exp_lives)) begin
            n_fail++;
            $display("FAIL timeout_lives got=%0d exp=%0d", lives_left, exp_lives);
        end
        wait_silent(11);
    endtask

    task automatic test_game_over();
        step();
        n_checks++;
        if ({game_over, win, piezo_out} !== {2'b10, 4'd0}) begin
            n_fail++;
            $display("FAIL game_over got over=%b win=%b piezo=%0d exp=1 0 0", game_over, win, piezo_out);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({game_over, piezo_out} !== {1'b1, 4'd0}) begin
                n_fail++;
                $display("FAIL over_hold cyc=%0d got over=%b piezo=%0d exp=1 0", i, game_over, piezo_out);
            end
        end
    endtask

    task automatic test_double_press();
        btn = 4'b0011;
        step();
        n_checks++;
        if ({success, fail} !== 2'b01) begin
            n_fail++;
            $display("FAIL double_fail got succ/fail=%b exp=01", {success, fail});
        end
        n_checks++;
        if (lives_left !== 2'd0) begin
            n_fail++;
            $display("FAIL double_lives got=%0d exp=0", lives_left);
        end
        btn = 4'd0;
        wait_silent(11);
    endtask

    task automatic test_reset_in_celeb();
        show(2, 2, 1'b1, -1);
        clear_level(2);
        wait_silent(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({piezo_out, led_out, success, fail, win, game_over} !== 12'd0) begin
            n_fail++;
            $display("FAIL celeb_reset got piezo=%0d led=%0d s=%b f=%b w=%b o=%b exp=all 0", piezo_out, led_out, success, fail, win, game_over);
        end
        n_checks++;
        if ({level, lives_left} !== {3'd2, 2'd2}) begin
            n_fail++;
            $display("FAIL celeb_reset_regs got lvl=%0d lives=%0d exp=2 2", level, lives_left);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if ({piezo_out, success, fail} !== 6'd0) begin
                n_fail++;
                $display("FAIL post_reset_idle cyc=%0d piezo=%0d s=%b f=%b exp=0 0 0", i, piezo_out, success, fail);
            end
        end
    endtask

    task automatic test_win();
        show(2, 2, 1'b1, -1);
        clear_level(2);
        wait_silent(11);
        show(3, 2, 1'b0, -1);
        clear_level(3);
        wait_silent(11);
        step();
        n_checks++;
        if ({win, game_over, piezo_out} !== {2'b10, 4'd0}) begin
            n_fail++;
            $display("FAIL win_flag got win=%b over=%b piezo=%0d exp=1 0 0", win, game_over, piezo_out);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if ({win, piezo_out, success, fail} !== {1'b1, 6'd0}) begin
                n_fail++;
                $display("FAIL win_hold cyc=%0d win=%b piezo=%0d s=%b f=%b exp=1 0 0 0", i, win, piezo_out, success, fail);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        btn   = 4'd0;
        test_reset();
        show(2, 2, 1'b1, -1);
        test_correct_round();
        test_wrong_press();
        test_timeout(0);
        test_game_over();
        // Restart from OVER; the start pulse 16 cycles in lands in SHOW_ON.
        show(2, 2, 1'b1, 16);
        test_timeout(1);
        show(2, 1, 1'b0, -1);
        test_double_press();
        test_game_over();
        test_reset_in_celeb();
        test_win();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
